// File: rtl/intc.sv
// Vectored interrupt controller: synchronises timer/gpio lines, latches
// pending state and runs a req/ack/eoi handshake with the core.
module intc #(
  parameter int N_SRC = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ier_we,
  input  logic             itr_we,
  input  logic             ipr_we,
  input  logic             irq_ack,
  input  logic             eoi,
  output logic             irq,
  output logic [4:0]       irq_id,
  output logic [WIDTH-1:0] o_ier,
  output logic [WIDTH-1:0] o_itr,
  output logic [WIDTH-1:0] o_ipr,
  output logic [WIDTH-1:0] o_isr
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [N_SRC-1:0] s1;
  logic [N_SRC-1:0] s2;
  logic [N_SRC-1:0] s3;
  logic [N_SRC-1:0] ier;
  logic [N_SRC-1:0] itr;
  logic [N_SRC-1:0] ipr;
  logic [N_SRC-1:0] ipr_d;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] clr_ack;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] id_hot;
  logic [N_SRC-1:0] wdata;
  logic [4:0]       sel;
  logic [4:0]       id_d;
  logic             irq_d;
  logic             ack_clr;
  logic             id_active;
  logic             busy;
  logic             unused_data;

  assign wdata       = data_in[N_SRC-1:0];
  assign unused_data = ^data_in;

  // Two-flop synchroniser plus a history flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= src;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ier <= '0;
      itr <= '0;
    end else begin
      if (ier_we) ier <= wdata;
      if (itr_we) itr <= wdata;
    end
  end

  assign rise    = s2 & ~s3;
  assign w1c     = ipr_we ? wdata : '0;
  assign id_hot  = {{(N_SRC-1){1'b0}}, 1'b1} << irq_id;
  assign clr_ack = ack_clr ? id_hot : '0;

  // Edge sources: a new rise beats any clear; level sources mirror s2
  always_comb begin
    ipr_d = (itr & (rise | (ipr & ~w1c & ~clr_ack)))
          | (~itr & s2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ipr <= '0;
    else     ipr <= ipr_d;
  end

  assign active    = ipr & ier;
  assign id_active = |(active & id_hot);

  always_comb begin
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) sel = 5'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      irq     <= 1'b0;
      irq_id  <= '0;
    end else begin
      state_q <= state_d;
      irq     <= irq_d;
      irq_id  <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    irq_d   = 1'b0;
    id_d    = irq_id;
    ack_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|active) begin
          state_d = REQ;
          irq_d   = 1'b1;
          id_d    = sel;
        end
      end
      REQ: begin
        if (!id_active) begin
          state_d = IDLE;
        end else if (irq_ack) begin
          state_d = SERVICE;
          ack_clr = 1'b1;
        end else begin
          irq_d = 1'b1;
        end
      end
      SERVICE: begin
        if (eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == SERVICE);
  assign o_ier = WIDTH'(ier);
  assign o_itr = WIDTH'(itr);
  assign o_ipr = WIDTH'(ipr);
  assign o_isr = WIDTH'({busy, busy ? irq_id : 5'd0});

endmodule

// File: tb/tb_intc.sv
// Scoreboard bench for intc: expectations are queued as stimulus
// is driven and popped at each negedge observation point.
module tb_intc;

  logic        clk;
  logic        rst;
  logic [7:0]  src;
  logic [31:0] data_in;
  logic        ier_we;
  logic        itr_we;
  logic        ipr_we;
  logic        irq_ack;
  logic        eoi;
  logic        irq;
  logic [4:0]  irq_id;
  logic [31:0] o_ier;
  logic [31:0] o_itr;
  logic [31:0] o_ipr;
  logic [31:0] o_isr;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp;
  int   n_bad;

  intc #(.N_SRC(8), .WIDTH(32)) dut (
    .clk(clk), .rst(rst), .src(src), .data_in(data_in),
    .ier_we(ier_we), .itr_we(itr_we), .ipr_we(ipr_we),
    .irq_ack(irq_ack), .eoi(eoi), .irq(irq), .irq_id(irq_id),
    .o_ier(o_ier), .o_itr(o_itr), .o_ipr(o_ipr), .o_isr(o_isr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string n, input logic [31:0] v);
    exp_t x;
    x.name = n;
    x.val  = v;
    sb.push_back(x);
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  task automatic wr_ier(input logic [31:0] v);
    nclk(); data_in = v; ier_we = 1'b1;
    nclk(); ier_we = 1'b0;
  endtask

  task automatic wr_itr(input logic [31:0] v);
    nclk(); data_in = v; itr_we = 1'b1;
    nclk(); itr_we = 1'b0;
  endtask

  task automatic test_reset();
    push("rst_irq", 0); push("rst_id", 0); push("rst_ipr", 0);
    push("rst_ier", 0); push("rst_isr", 0);
    rst = 1'b1;
    nclk(); nclk();
    e = sb.pop_front(); n_cmp++; if (32'(irq) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq, e.val); end
    e = sb.pop_front(); n_cmp++; if (32'(irq_id) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq_id, e.val); end
    e = sb.pop_front(); n_cmp++; if (o_ipr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_ipr, e.val); end
    e = sb.pop_front(); n_cmp++; if (o_ier !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_ier, e.val); end
    e = sb.pop_front(); n_cmp++; if (o_isr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_isr, e.val); end
    rst = 1'b0;
  endtask

  task automatic test_regs();
    push("ier_mask", 32'h0000_00FF);
    push("itr_mask", 32'h0000_0000);
    wr_ier(32'hFFFF_FFFF);
    e = sb.pop_front(); n_cmp++; if (o_ier !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_ier, e.val); end
    wr_itr(32'hFFFF_FF00);
    e = sb.pop_front(); n_cmp++; if (o_itr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_itr, e.val); end
    wr_ier(32'h0);
  endtask

  task automatic test_edge_basic();
    wr_itr(32'h01);
    wr_ier(32'h01);
    push("t1_ipr_early", 0); push("t1_ipr", 1); push("t1_irq_pre", 0);
    push("t1_irq", 1); push("t1_id", 0);
    push("t1_irq_ack", 0); push("t1_ipr_clr", 0); push("t1_isr", 32'h20);
    push("t1_isr_eoi", 0); push("t1_irq_eoi", 0);
    src = 8'h01;
    nclk(); src = 8'h00;
    nclk();
    e = sb.pop_front(); n_cmp++; if (o_ipr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_ipr, e.val); end
    nclk();
    e = sb.pop_front(); n_cmp++; if (o_ipr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_ipr, e.val); end
    e = sb.pop_front(); n_cmp++; if (32'(irq) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq, e.val); end
    nclk();
    e = sb.pop_front(); n_cmp++; if (32'(irq) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq, e.val); end
    e = sb.pop_front(); n_cmp++; if (32'(irq_id) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq_id, e.val); end
    irq_ack = 1'b1;
    nclk(); irq_ack = 1'b0;
    e = sb.pop_front(); n_cmp++; if (32'(irq) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq, e.val); end
    e = sb.pop_front(); n_cmp++; if (o_ipr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_ipr, e.val); end
    e = sb.pop_front(); n_cmp++; if (o_isr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_isr, e.val); end
    eoi = 1'b1;
    nclk(); eoi = 1'b0;
    e = sb.pop_front(); n_cmp++; if (o_isr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_isr, e.val); end
    nclk();
    e = sb.pop_front(); n_cmp++; if (32'(irq) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq, e.val); end
  endtask

  task automatic test_priority();
    wr_itr(32'h0F);
    wr_ier(32'h0F);
    push("t2_ipr", 32'h0A); push("t2_id1", 1); push("t2_ipr_left", 32'h08);
    push("t2_isr", 32'h21); push("t2_irq_gap", 0); push("t2_irq_re", 1);
    push("t2_id3", 3); push("t2_ipr_end", 0);
    src = 8'h0A;
    nclk(); src = 8'h00;
    nclk(); nclk();
    e = sb.pop_front(); n_cmp++; if (o_ipr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_ipr, e.val); end
    nclk();
    e = sb.pop_front(); n_cmp++; if (32'(irq_id) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq_id, e.val); end
    irq_ack = 1'b1;
    nclk(); irq_ack = 1'b0;
    e = sb.pop_front(); n_cmp++; if (o_ipr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_ipr, e.val); end
    e = sb.pop_front(); n_cmp++; if (o_isr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_isr, e.val); end
    eoi = 1'b1;
    nclk(); eoi = 1'b0;
    e = sb.pop_front(); n_cmp++; if (32'(irq) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq, e.val); end
    nclk();
    e = sb.pop_front(); n_cmp++; if (32'(irq) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq, e.val); end
    e = sb.pop_front(); n_cmp++; if (32'(irq_id) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq_id, e.val); end
    irq_ack = 1'b1;
    nclk(); irq_ack = 1'b0; eoi = 1'b1;
    nclk(); eoi = 1'b0;
    e = sb.pop_front(); n_cmp++; if (o_ipr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_ipr, e.val); end
  endtask

  task automatic test_level();
    wr_itr(32'h00);
    wr_ier(32'h04);
    push("t3_ipr", 32'h04); push("t3_id2", 2); push("t3_ipr_w1c", 32'h04);
    push("t3_irq_hold", 1); push("t3_ipr_drop", 0); push("t3_irq_drop", 0);
    push("t3_isr", 0);
    src = 8'h04;
    nclk(); nclk(); nclk();
    e = sb.pop_front(); n_cmp++; if (o_ipr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_ipr, e.val); end
    nclk();
    e = sb.pop_front(); n_cmp++; if (32'(irq_id) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq_id, e.val); end
    data_in = 32'h04; ipr_we = 1'b1;
    nclk(); ipr_we = 1'b0;
    e = sb.pop_front(); n_cmp++; if (o_ipr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_ipr, e.val); end
    e = sb.pop_front(); n_cmp++; if (32'(irq) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq, e.val); end
    src = 8'h00;
    nclk(); nclk(); nclk();
    e = sb.pop_front(); n_cmp++; if (o_ipr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_ipr, e.val); end
    nclk();
    e = sb.pop_front(); n_cmp++; if (32'(irq) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq, e.val); end
    e = sb.pop_front(); n_cmp++; if (o_isr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_isr, e.val); end
  endtask

  task automatic test_enable_w1c();
    wr_itr(32'h20);
    wr_ier(32'h00);
    push("t4_ipr", 32'h20); push("t4_irq_off", 0); push("t4_irq_en", 1);
    push("t4_id5", 5); push("t4_ipr_w1c", 0); push("t4_irq_drop", 0);
    src = 8'h20;
    nclk(); src = 8'h00;
    nclk(); nclk();
    e = sb.pop_front(); n_cmp++; if (o_ipr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_ipr, e.val); end
    nclk();
    e = sb.pop_front(); n_cmp++; if (32'(irq) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq, e.val); end
    wr_ier(32'h20);
    nclk();
    e = sb.pop_front(); n_cmp++; if (32'(irq) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq, e.val); end
    e = sb.pop_front(); n_cmp++; if (32'(irq_id) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq_id, e.val); end
    data_in = 32'h20; ipr_we = 1'b1;
    nclk(); ipr_we = 1'b0;
    e = sb.pop_front(); n_cmp++; if (o_ipr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_ipr, e.val); end
    nclk();
    e = sb.pop_front(); n_cmp++; if (32'(irq) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq, e.val); end
  endtask

  task automatic test_set_wins();
    wr_itr(32'h01);
    wr_ier(32'h01);
    push("t5_ipr_set", 1); push("t5_irq_idle", 0); push("t5_isr_idle", 0);
    push("t5_irq", 1); push("t5_id0", 0); push("t5_irq_eoi", 1);
    push("t5_isr_eoi", 0); push("t5_isr_svc", 32'h20); push("t5_ipr_clr", 0);
    src = 8'h01;
    nclk(); src = 8'h00;
    nclk(); data_in = 32'h01; ipr_we = 1'b1; irq_ack = 1'b1;
    nclk(); ipr_we = 1'b0; irq_ack = 1'b0;
    e = sb.pop_front(); n_cmp++; if (o_ipr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_ipr, e.val); end
    e = sb.pop_front(); n_cmp++; if (32'(irq) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq, e.val); end
    e = sb.pop_front(); n_cmp++; if (o_isr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_isr, e.val); end
    nclk();
    e = sb.pop_front(); n_cmp++; if (32'(irq) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq, e.val); end
    e = sb.pop_front(); n_cmp++; if (32'(irq_id) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq_id, e.val); end
    eoi = 1'b1;
    nclk(); eoi = 1'b0;
    e = sb.pop_front(); n_cmp++; if (32'(irq) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq, e.val); end
    e = sb.pop_front(); n_cmp++; if (o_isr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_isr, e.val); end
    irq_ack = 1'b1;
    nclk(); irq_ack = 1'b0;
    e = sb.pop_front(); n_cmp++; if (o_isr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_isr, e.val); end
    e = sb.pop_front(); n_cmp++; if (o_ipr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_ipr, e.val); end
  endtask

  task automatic test_reset_in_service();
    push("t6_isr", 0); push("t6_ier", 0); push("t6_itr", 0); push("t6_irq", 0);
    push("t6_irq_new", 1); push("t6_id_new", 0); push("t6_isr_new", 32'h20);
    push("t6_isr_end", 0);
    nclk();
    #2 rst = 1'b1;
    #1;
    e = sb.pop_front(); n_cmp++; if (o_isr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_isr, e.val); end
    e = sb.pop_front(); n_cmp++; if (o_ier !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_ier, e.val); end
    e = sb.pop_front(); n_cmp++; if (o_itr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_itr, e.val); end
    e = sb.pop_front(); n_cmp++; if (32'(irq) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq, e.val); end
    nclk(); rst = 1'b0;
    wr_itr(32'h01);
    wr_ier(32'h01);
    src = 8'h01;
    nclk(); src = 8'h00;
    nclk(); nclk(); nclk();
    e = sb.pop_front(); n_cmp++; if (32'(irq) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq, e.val); end
    e = sb.pop_front(); n_cmp++; if (32'(irq_id) !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, irq_id, e.val); end
    irq_ack = 1'b1;
    nclk(); irq_ack = 1'b0;
    e = sb.pop_front(); n_cmp++; if (o_isr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_isr, e.val); end
    eoi = 1'b1;
    nclk(); eoi = 1'b0;
    e = sb.pop_front(); n_cmp++; if (o_isr !== e.val) begin n_bad++; $display("FAIL %s got %0h want %0h", e.name, o_isr, e.val); end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    src     = '0;
    data_in = '0;
    ier_we  = 1'b0;
    itr_we  = 1'b0;
    ipr_we  = 1'b0;
    irq_ack = 1'b0;
    eoi     = 1'b0;
    test_reset();
    test_regs();
    test_edge_basic();
    test_priority();
    test_level();
    test_enable_w1c();
    test_set_wins();
    test_reset_in_service();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
